csr_io_arbiter: RTL and testbench

Shares the core's single CSR I/O request/response port among NUM_REQS host-side requesters (debug/DM, AFU MMIO, scope, …). Round-robin arbitration with one transaction in flight; read responses are routed back to the owning requester. A response watchdog returns an error response if the pipeline never answers. Sits between the host CSR fabric and the core pipeline's csr_req_*/csr_rsp_* ports.

---
 rtl/csr_io_arb_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 36 +++
 rtl/csr_io_arbiter.sv | 167 ++++++++++++++++
 tb/tb_csr_io_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_io_arb_pkg.sv
// Shared types and constants for the CSR I/O arbiter.
package csr_io_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Data returned to the requester when the pipeline never answers.
   localparam int TIMEOUT_DATA = 0;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational cyclic priority select: the first valid bit at or after ptr_i wins.
module rr_priority_picker #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] idx_o,
   output logic          any_valid_o
);

   logic [N-1:0] rotated;
   int           offset;
   int           sum;

   // Rotate so ptr_i sits at bit 0, pick the lowest set bit, then rotate back.
   always_comb begin
      rotated     = N'({valid_i, valid_i} >> ptr_i);
      offset      = 0;
      any_valid_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            offset      = k;
            any_valid_o = 1'b1;
         end
      end
      sum = int'(ptr_i) + offset;
      if (sum >= N) begin
         sum = sum - N;
      end
      idx_o   = PW'(sum);
      grant_o = any_valid_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/csr_io_arbiter.sv
// Round-robin arbiter sharing the core CSR request/response port among host requesters,
// one transaction in flight, with a response watchdog.
module csr_io_arbiter
   import csr_io_arb_pkg::*;
#(
   parameter int NUM_REQS       = 4,
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            req_valid,
   input  logic [NUM_REQS-1:0]            req_rw,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQS-1:0]            req_ready,
   output logic [NUM_REQS-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_data,
   output logic                           rsp_err,
   input  logic [NUM_REQS-1:0]            rsp_ready,
   output logic                           csr_req_valid,
   output logic                           csr_req_rw,
   output logic [ADDR_WIDTH-1:0]          csr_req_addr,
   output logic [DATA_WIDTH-1:0]          csr_req_data,
   input  logic                           csr_req_ready,
   input  logic                           csr_rsp_valid,
   input  logic [DATA_WIDTH-1:0]          csr_rsp_data,
   output logic                           csr_rsp_ready,
   output logic                           busy
);

   localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [PW-1:0] LAST_REQ   = PW'(NUM_REQS - 1);

   arb_state_e            state_q, state_d;
   logic [PW-1:0]         owner_q, owner_d;
   logic [PW-1:0]         ptr_q, ptr_d;
   logic                  rw_q, rw_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [TW-1:0]         timer_q, timer_d;

   logic [NUM_REQS-1:0]   grantVec;
   logic [PW-1:0]         grantIdx;
   logic                  grantAny;
   logic [PW-1:0]         ownerNext;
   logic [ADDR_WIDTH-1:0] addrArr [NUM_REQS];
   logic [DATA_WIDTH-1:0] dataArr [NUM_REQS];

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
      assign addrArr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign dataArr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_priority_picker #(
      .N  (NUM_REQS),
      .PW (PW)
   ) u_picker (
      .valid_i     (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grantVec),
      .idx_o       (grantIdx),
      .any_valid_o (grantAny)
   );

   assign ownerNext = (owner_q == LAST_REQ) ? '0 : owner_q + PW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

   // The pointer only moves when a transaction completes, so dropped requests never shift fairness.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (grantAny) begin
               state_d = ISSUE;
               owner_d = grantIdx;
               rw_d    = req_rw[grantIdx];
               addr_d  = addrArr[grantIdx];
               wdata_d = dataArr[grantIdx];
            end
         end
         ISSUE: begin
            if (csr_req_ready) begin
               if (rw_q) begin
                  state_d = IDLE;
                  ptr_d   = ownerNext;
               end else begin
                  state_d = WAIT;
                  timer_d = '0;
               end
            end
         end
         WAIT: begin
            if (csr_rsp_valid) begin
               state_d = RESP;
               rdata_d = csr_rsp_data;
               err_d   = 1'b0;
            end else begin
               timer_d = timer_q + TW'(1);
               if (TIMEOUT_CYCLES != 0 && timer_q == TIMER_LAST) begin
                  state_d = RESP;
                  rdata_d = DATA_WIDTH'(TIMEOUT_DATA);
                  err_d   = 1'b1;
               end
            end
         end
         RESP: begin
            if (rsp_ready[owner_q]) begin
               state_d = IDLE;
               ptr_d   = ownerNext;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are also forced low while reset is held.
   always_comb begin
      req_ready     = (reset && state_q == IDLE) ? grantVec : '0;
      csr_req_valid = reset && (state_q == ISSUE);
      csr_req_rw    = rw_q;
      csr_req_addr  = addr_q;
      csr_req_data  = wdata_q;
      csr_rsp_ready = reset && (state_q != RESP);
      rsp_valid     = (reset && state_q == RESP) ? (NUM_REQS'(1) << owner_q) : '0;
      rsp_data      = rdata_q;
      rsp_err       = err_q;
      busy          = (state_q != IDLE);
   end

endmodule

// File: tb/tb_csr_io_arbiter.sv
// Self-checking bench for csr_io_arbiter: grant table, directed corner sequences, random traffic.
module tb_csr_io_arbiter;

   localparam int NR = 4;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_rw;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              rsp_err;
   logic [NR-1:0]     rsp_ready;
   logic              csr_req_valid;
   logic              csr_req_rw;
   logic [AW-1:0]     csr_req_addr;
   logic [DW-1:0]     csr_req_data;
   logic              csr_req_ready;
   logic              csr_rsp_valid;
   logic [DW-1:0]     csr_rsp_data;
   logic              csr_rsp_ready;
   logic              busy;

   always #5 clk = ~clk;

   csr_io_arbiter #(
      .NUM_REQS       (NR),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_rw        (req_rw),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .rsp_ready     (rsp_ready),
      .csr_req_valid (csr_req_valid),
      .csr_req_rw    (csr_req_rw),
      .csr_req_addr  (csr_req_addr),
      .csr_req_data  (csr_req_data),
      .csr_req_ready (csr_req_ready),
      .csr_rsp_valid (csr_rsp_valid),
      .csr_rsp_data  (csr_rsp_data),
      .csr_rsp_ready (csr_rsp_ready),
      .busy          (busy)
   );

   typedef struct {
      logic [NR-1:0] mask;
      int            expIdx;
   } grant_vec_t;

   int            vecCount = 0;
   int            errCount = 0;
   int            mPtr     = 0;
   logic [AW-1:0] tAddr [NR];
   logic [DW-1:0] tData [NR];
   logic [NR-1:0] tRw;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic applyStimulus(input logic [NR-1:0] mask);
      req_valid = mask;
      req_rw    = tRw;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = tAddr[i];
         req_data[i*DW +: DW] = tData[i];
      end
   endtask

   // Reference arbitration: first requester at or after the pointer, wrapping around.
   function automatic int modelGrant(input logic [NR-1:0] mask, input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic doReset();
      reset = 1'b0;
      applyStimulus('0);
      tick();
      tick();
      reset = 1'b1;
      mPtr  = 0;
   endtask

   // One complete transaction from an idle arbiter; rspLat < 0 or >= TO means no pipeline answer.
   task automatic doTxn(input logic [NR-1:0] mask, input int expIdx, input int reqStall,
                        input int rspLat, input int rspStall, input logic [DW-1:0] pipeData);
      logic [NR-1:0] oneHot;
      logic          realRsp;
      logic [DW-1:0] expData;
      oneHot = NR'(1) << expIdx;
      applyStimulus(mask);
      settle();
      checkOutput("grant", 64'(req_ready), 64'(oneHot));
      tick();
      applyStimulus('0);
      for (int s = 0; s <= reqStall; s++) begin
         csr_req_ready = (s == reqStall);
         settle();
         checkOutput("issueValid", 64'(csr_req_valid), 64'd1);
         checkOutput("issueAddr", 64'(csr_req_addr), 64'(tAddr[expIdx]));
         checkOutput("issueData", 64'(csr_req_data), 64'(tData[expIdx]));
         checkOutput("issueRw", 64'(csr_req_rw), 64'(tRw[expIdx]));
         checkOutput("issueBusy", 64'(busy), 64'd1);
         tick();
      end
      csr_req_ready = 1'b0;
      if (tRw[expIdx]) begin
         settle();
         checkOutput("postedBusy", 64'(busy), 64'd0);
         checkOutput("postedNoRsp", 64'(rsp_valid), 64'd0);
         mPtr = (expIdx + 1) % NR;
         return;
      end
      realRsp = (rspLat >= 0 && rspLat < TO);
      for (int c = 0; c < TO; c++) begin
         if (realRsp && c == rspLat) begin
            csr_rsp_valid = 1'b1;
            csr_rsp_data  = pipeData;
            settle();
            checkOutput("waitAccept", 64'(csr_rsp_ready), 64'd1);
            tick();
            csr_rsp_valid = 1'b0;
            break;
         end
         settle();
         checkOutput("waitRspReady", 64'(csr_rsp_ready), 64'd1);
         checkOutput("waitNoRsp", 64'(rsp_valid), 64'd0);
         tick();
      end
      expData = realRsp ? pipeData : '0;
      for (int s = 0; s <= rspStall; s++) begin
         rsp_ready = (s == rspStall) ? oneHot : ~oneHot;
         settle();
         checkOutput("rspValid", 64'(rsp_valid), 64'(oneHot));
         checkOutput("rspData", 64'(rsp_data), 64'(expData));
         checkOutput("rspErr", 64'(rsp_err), 64'(!realRsp));
         checkOutput("rspCsrReady", 64'(csr_rsp_ready), 64'd0);
         tick();
      end
      rsp_ready = '0;
      settle();
      checkOutput("rspDoneBusy", 64'(busy), 64'd0);
      checkOutput("rspDoneValid", 64'(rsp_valid), 64'd0);
      mPtr = (expIdx + 1) % NR;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      grant_vec_t table_q [8];
      int         lat;
      logic [NR-1:0] mask;
      table_q = '{
         '{4'b0001, 0}, '{4'b0001, 0}, '{4'b1001, 3}, '{4'b1111, 0},
         '{4'b1101, 2}, '{4'b0110, 1}, '{4'b0000, -1}, '{4'b0011, 0}
      };
      for (int i = 0; i < NR; i++) begin
         tAddr[i] = AW'(12'h100 + i);
         tData[i] = DW'(32'h5000_0000 + i);
      end
      tRw           = '1;
      rsp_ready     = '0;
      csr_req_ready = 1'b0;
      csr_rsp_valid = 1'b0;
      csr_rsp_data  = '0;
      reset         = 1'b1;
      applyStimulus('0);
      #1;
      reset = 1'b0;
      applyStimulus(4'b1111);
      csr_rsp_valid = 1'b1;
      settle();
      checkOutput("rstReqReady", 64'(req_ready), 64'd0);
      checkOutput("rstCsrRspReady", 64'(csr_rsp_ready), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstCsrReqValid", 64'(csr_req_valid), 64'd0);
      checkOutput("rstRspValid", 64'(rsp_valid), 64'd0);
      csr_rsp_valid = 1'b0;
      doReset();

      // Posted writes walking the round-robin pointer through a fixed sequence.
      for (int i = 0; i < 8; i++) begin
         if (table_q[i].expIdx < 0) begin
            applyStimulus(table_q[i].mask);
            settle();
            checkOutput("tblNoGrant", 64'(req_ready), 64'd0);
            tick();
            settle();
            checkOutput("tblIdleBusy", 64'(busy), 64'd0);
            applyStimulus('0);
            tick();
         end else begin
            doTxn(table_q[i].mask, table_q[i].expIdx, 0, 0, 0, '0);
            tick();
         end
      end

      tAddr[0] = 12'hCC0;
      tRw[0]   = 1'b0;
      doTxn(4'b0001, 0, 0, 4, 0, 32'h0000_1234);
      tick();

      doReset();
      tRw = '0;
      for (int i = 0; i < 5; i++) begin
         doTxn(4'b1111, i % NR, 0, 0, 0, DW'(32'h1000 + i));
      end

      tRw[2]   = 1'b1;
      tData[2] = 32'hA5A5_A5A5;
      doTxn(4'b0100, modelGrant(4'b0100, mPtr), 5, 0, 0, '0);

      // Timeout, then a late pipeline answer that must be swallowed.
      tRw[0] = 1'b0;
      doTxn(4'b0001, 0, 0, -1, 0, '0);
      csr_rsp_valid = 1'b1;
      csr_rsp_data  = 32'hDEAD_BEEF;
      settle();
      checkOutput("strayReady", 64'(csr_rsp_ready), 64'd1);
      tick();
      csr_rsp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         checkOutput("strayNoRsp", 64'(rsp_valid), 64'd0);
         checkOutput("strayBusy", 64'(busy), 64'd0);
         tick();
      end

      tRw[1] = 1'b0;
      doTxn(4'b0010, 1, 0, TO - 1, 3, 32'hBEEF_0001);

      // Reset while a read is in flight.
      tRw[1] = 1'b1;
      doTxn(4'b0010, 1, 0, 0, 0, '0);
      tRw[2] = 1'b0;
      applyStimulus(4'b0100);
      settle();
      checkOutput("midGrant", 64'(req_ready), 64'b0100);
      tick();
      applyStimulus('0);
      csr_req_ready = 1'b1;
      tick();
      csr_req_ready = 1'b0;
      tick();
      settle();
      checkOutput("midWaitBusy", 64'(busy), 64'd1);
      applyStimulus(4'b1111);
      reset = 1'b0;
      #1;
      checkOutput("midRstReqReady", 64'(req_ready), 64'd0);
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      checkOutput("midRstCsrRspReady", 64'(csr_rsp_ready), 64'd0);
      checkOutput("midRstRspValid", 64'(rsp_valid), 64'd0);
      checkOutput("midRstCsrReqValid", 64'(csr_req_valid), 64'd0);
      checkOutput("midRstAddr", 64'(csr_req_addr), 64'd0);
      checkOutput("midRstErr", 64'(rsp_err), 64'd0);
      tick();
      tick();
      reset = 1'b1;
      mPtr  = 0;
      tRw   = '1;
      doTxn(4'b1001, 0, 0, 0, 0, '0);
      doTxn(4'b1000, 3, 0, 0, 0, '0);

      for (int n = 0; n < 150; n++) begin
         mask = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) begin
            tRw[i]   = 1'($urandom_range(0, 1));
            tAddr[i] = AW'($urandom);
            tData[i] = DW'($urandom);
         end
         lat = $urandom_range(0, TO + 1);
         if (lat >= TO) lat = -1;
         doTxn(mask, modelGrant(mask, mPtr), $urandom_range(0, 3), lat,
               $urandom_range(0, 2), DW'($urandom));
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
